mem_cmd_host: RTL and testbench
===============================

// Module: mem_cmd_host
// PURPOSE
//  Initiator for the 128-bit load/busy memory-target command interface. Turns host word writes into
//  target write commands (data[127]=1, data[31:0]=word, key[6:0]=addr), issues the readback command
//  (data=0) and captures the streamed 32-bit words into a local buffer for host read-out.
//  Sits between the host register file and the memory target under power analysis.
// PARAMETERS
//  DEPTH    128  words captured per readback (target memory depth)
//  RD_SKIP  2    target-output cycles discarded after the readback load pulse, before capture
//  TIMEOUT  255  max cycles in WR_WAIT before abort
// PORTS
//  clk         in   1    clock
//  rst         in   1    reset, asynchronous, active-high
//  wr_valid_i  in   1    host write request
//  wr_ready_o  out  1    = (state==IDLE) & ~rd_start_i; request accepted when valid&ready
//  wr_addr_i   in   7    target word address
//  wr_data_i   in   32   word to write
//  rd_start_i  in   1    start readback; honoured only in IDLE
//  rd_done_o   out  1    one-cycle pulse when capture completes
//  cap_addr_i  in   clog2(DEPTH)  capture-buffer read address
//  cap_data_o  out  32   capture-buffer read data, registered, 1-cycle latency
//  busy_o      out  1    state != IDLE
//  err_o       out  1    sticky: write-ack timeout; cleared by rst or by next accepted command
//  tgt_load_o  out  1    command pulse to target
//  tgt_data_o  out  128  command data
//  tgt_key_o   out  128  command key ({121'b0, addr} for writes, 0 for readback)
//  tgt_busy_i  in   1    target busy
//  tgt_data_i  in   128  target read stream; only [31:0] captured
// BEHAVIOUR
//  Reset: state IDLE, tgt_load_o=0, tgt_data_o=0, tgt_key_o=0, rd_done_o=0, err_o=0, cap_data_o=0,
//   counters 0. Capture buffer contents are NOT reset. Reset mid-operation aborts to IDLE immediately.
//  All target outputs registered. tgt_load_o is high exactly one cycle per command; data/key return to 0
//   the cycle after the pulse.
//  FSM: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_SKIP, RD_CAP, RD_DONE.
//  IDLE: rd_start_i -> RD_ISSUE (priority over wr_valid_i in same cycle; write is not accepted);
//   else wr_valid_i -> latch addr/data, -> WR_ISSUE.
//  WR_ISSUE (1 cycle): tgt_load_o=1, tgt_data_o={1'b1,95'b0,data}, tgt_key_o={121'b0,addr} -> WR_WAIT.
//  WR_WAIT: needs tgt_busy_i seen 1 then 0 -> IDLE. Cycle counter from 0; reaching TIMEOUT -> err_o=1,
//   -> IDLE. Busy never rising also times out.
//  RD_ISSUE (1 cycle): tgt_load_o=1, tgt_data_o=0, tgt_key_o=0 -> RD_SKIP (or RD_CAP if RD_SKIP==0).
//  RD_SKIP: discard RD_SKIP cycles of tgt_data_i -> RD_CAP.
//  RD_CAP: each cycle buf[cnt] <= tgt_data_i[31:0], cnt 0..DEPTH-1; after writing DEPTH-1 -> RD_DONE.
//   tgt_busy_i ignored during readback.
//  RD_DONE (1 cycle): rd_done_o=1 -> IDLE. Total readback = 1+RD_SKIP+DEPTH+1 cycles from leaving IDLE.
//  Accepting any command clears err_o. Host reads of the buffer are allowed at any time; during RD_CAP
//   they return whatever the buffer holds at that moment (no read-during-write bypass).
//  Address wrap: wr_addr_i is 7 bits, no range check; cnt width clog2(DEPTH), never wraps within a read.
// TESTING
//  1 write (addr 5, data 0xDEADBEEF) -> one tgt_load_o pulse, tgt_data_o=0x8000..00DEADBEEF,
//    tgt_key_o=5; busy 1-cycle response -> back to IDLE, wr_ready_o=1, err_o=0.
//  2 Readback vs target model holding mem[i]=i*3 -> rd_done_o after 1+2+128+1 cycles from rd_start_i;
//    cap_addr_i=10 -> cap_data_o=30 the next cycle.
//  3 Target never asserts busy -> err_o=1 after TIMEOUT cycles in WR_WAIT; next write clears it.
//  4 rd_start_i and wr_valid_i high together in IDLE -> wr_ready_o=0, readback runs, write accepted
//    only after rd_done_o.
//  5 rst pulsed in RD_CAP at word 40 -> all outputs 0 same cycle, IDLE; words 0..39 retained in buffer.
//  6 Back-to-back 3 writes (addr 0,1,2) -> three separate load pulses, each after the previous busy falls.

Source files
------------

// File: rtl/mem_cmd_host_if.sv
// Host and target signal bundle for mem_cmd_host.
// "master" is the command initiator's view and "slave" is the view of the surrounding host/target.
`timescale 1ns/1ps
interface mem_cmd_host_if #(
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);

  logic           wr_valid_i;
  logic           wr_ready_o;
  logic [6:0]     wr_addr_i;
  logic [31:0]    wr_data_i;
  logic           rd_start_i;
  logic           rd_done_o;
  logic [AW-1:0]  cap_addr_i;
  logic [31:0]    cap_data_o;
  logic           busy_o;
  logic           err_o;
  logic           tgt_load_o;
  logic [127:0]   tgt_data_o;
  logic [127:0]   tgt_key_o;
  logic           tgt_busy_i;
  logic [127:0]   tgt_data_i;

  modport master (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_start_i, cap_addr_i, tgt_busy_i, tgt_data_i,
    output wr_ready_o, rd_done_o, cap_data_o, busy_o, err_o, tgt_load_o, tgt_data_o, tgt_key_o
  );

  modport slave (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_start_i, cap_addr_i, tgt_busy_i, tgt_data_i,
    input  wr_ready_o, rd_done_o, cap_data_o, busy_o, err_o, tgt_load_o, tgt_data_o, tgt_key_o
  );
endinterface

// File: rtl/mem_cmd_host.sv
// Command initiator for a 128-bit load/busy memory target: issues word writes and a readback
// command, and captures the streamed read words into a local buffer for the host.
`timescale 1ns/1ps
module mem_cmd_host #(
  parameter int DEPTH   = 128,
  parameter int RD_SKIP = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_cmd_host_if.master    bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int SW  = $clog2(RD_SKIP + 1);
  localparam int CW0 = (AW > TW) ? AW : TW;
  localparam int CW  = (CW0 > SW) ? CW0 : SW;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_SKIP, S_RD_CAP, S_RD_DONE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           seen, seen_n;
  logic           err, err_n;
  logic           load_q, load_n;
  logic [127:0]   tdata_q, tdata_n;
  logic [127:0]   tkey_q, tkey_n;
  logic           done_q, done_n;
  logic           cap_we;
  logic [31:0]    cap_mem [DEPTH];
  logic [31:0]    cap_q;
  logic           unused_tgt_hi;

  // The target drives a full 128-bit stream but only the low word carries read data.
  assign unused_tgt_hi = ^bus.tgt_data_i[127:32];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seen_n  = seen;
    err_n   = err;
    load_n  = 1'b0;
    tdata_n = '0;
    tkey_n  = '0;
    done_n  = 1'b0;
    cap_we  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.rd_start_i) begin
          state_n = S_RD_ISSUE;
          load_n  = 1'b1;
          err_n   = 1'b0;
        end else if (bus.wr_valid_i) begin
          state_n = S_WR_ISSUE;
          load_n  = 1'b1;
          tdata_n = {1'b1, 95'b0, bus.wr_data_i};
          tkey_n  = {121'b0, bus.wr_addr_i};
          err_n   = 1'b0;
        end
      end
      S_WR_ISSUE: begin
        state_n = S_WR_WAIT;
        cnt_n   = '0;
        seen_n  = 1'b0;
      end
      S_WR_WAIT: begin
        // Acknowledge is a complete busy pulse; a target that never raises busy times out.
        if (seen && !bus.tgt_busy_i) begin
          state_n = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
          if (bus.tgt_busy_i) seen_n = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        cnt_n   = '0;
        state_n = (RD_SKIP == 0) ? S_RD_CAP : S_RD_SKIP;
      end
      S_RD_SKIP: begin
        if (cnt == CW'(RD_SKIP - 1)) begin
          cnt_n   = '0;
          state_n = S_RD_CAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RD_CAP: begin
        cap_we = 1'b1;
        if (cnt == CW'(DEPTH - 1)) begin
          state_n = S_RD_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RD_DONE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      seen    <= 1'b0;
      err     <= 1'b0;
      load_q  <= 1'b0;
      tdata_q <= '0;
      tkey_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      seen    <= seen_n;
      err     <= err_n;
      load_q  <= load_n;
      tdata_q <= tdata_n;
      tkey_q  <= tkey_n;
      done_q  <= done_n;
    end
  end

  // NOTE: the capture buffer is deliberately left out of reset so words captured before an abort survive.
  always_ff @(posedge clk) begin
    if (cap_we) cap_mem[cnt[AW-1:0]] <= bus.tgt_data_i[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cap_q <= '0;
    else     cap_q <= cap_mem[bus.cap_addr_i];
  end

  assign bus.wr_ready_o = (state == S_IDLE) && !bus.rd_start_i;
  assign bus.busy_o     = (state != S_IDLE);
  assign bus.err_o      = err;
  assign bus.rd_done_o  = done_q;
  assign bus.cap_data_o = cap_q;
  assign bus.tgt_load_o = load_q;
  assign bus.tgt_data_o = tdata_q;
  assign bus.tgt_key_o  = tkey_q;
endmodule

// File: tb/tb_mem_cmd_host.sv
// Bench for mem_cmd_host: behavioural memory target (array + busy pulse + delayed read stream)
// with a command scoreboard and an expected copy of the capture buffer.
`timescale 1ns/1ps
module tb_mem_cmd_host;
  localparam int DEPTH   = 128;
  localparam int RD_SKIP = 2;
  localparam int TIMEOUT = 255;
  localparam int AW      = $clog2(DEPTH);
  localparam int RD_LAT  = 1 + RD_SKIP + DEPTH + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_cmd_host_if #(.DEPTH(DEPTH)) bus ();

  mem_cmd_host #(.DEPTH(DEPTH), .RD_SKIP(RD_SKIP), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0]  tmem    [DEPTH];
  logic [31:0]  exp_buf [DEPTH];
  logic [127:0] exp_data_q [$];
  logic [127:0] exp_key_q  [$];
  int           wr_loads   [$];
  int           wr_lens    [$];
  int  busy_len = 1;
  int  busy_left = 0;
  int  stream_k = 0;
  int  cycle = 0;
  int  load_count = 0;
  int  last_wr_load = 0;
  int  last_done = 0;
  bit  streaming = 1'b0;
  bit  prev_load = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Target model: drives inputs for the current cycle, then observes the command issued this cycle.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        streaming      = 1'b0;
        busy_left      = 0;
        prev_load      = 1'b0;
        bus.tgt_busy_i = 1'b0;
      end else begin
        bus.tgt_busy_i = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (streaming && stream_k >= RD_SKIP)
          bus.tgt_data_i = {$urandom, $urandom, $urandom, tmem[stream_k - RD_SKIP]};
        else
          bus.tgt_data_i = {$urandom, $urandom, $urandom, $urandom};
        if (streaming) begin
          stream_k++;
          if (stream_k == RD_SKIP + DEPTH) streaming = 1'b0;
        end
        if (bus.tgt_load_o) begin
          load_count++;
          check("load_one_cycle", prev_load, 1'b0);
          if (bus.tgt_data_o[127]) begin
            tmem[bus.tgt_key_o[6:0]] = bus.tgt_data_o[31:0];
            busy_left    = busy_len;
            last_wr_load = cycle;
            wr_loads.push_back(cycle);
            wr_lens.push_back(busy_len);
            check("wr_cmd_expected", exp_data_q.size() > 0, 1'b1);
            if (exp_data_q.size() > 0) begin
              check("wr_cmd_data", bus.tgt_data_o, exp_data_q.pop_front());
              check("wr_cmd_key", bus.tgt_key_o, exp_key_q.pop_front());
            end
          end else begin
            check("rd_cmd_data", bus.tgt_data_o, '0);
            check("rd_cmd_key", bus.tgt_key_o, '0);
            streaming = 1'b1;
            stream_k  = 0;
          end
        end else if (prev_load) begin
          check("cmd_data_clear", bus.tgt_data_o, '0);
          check("cmd_key_clear", bus.tgt_key_o, '0);
        end
        if (bus.rd_done_o) last_done = cycle;
        prev_load = bus.tgt_load_o;
      end
    end
  end

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    int g;
    exp_data_q.push_back({1'b1, 95'b0, d});
    exp_key_q.push_back({121'b0, a});
    bus.wr_addr_i  = a;
    bus.wr_data_i  = d;
    bus.wr_valid_i = 1'b1;
    #1;
    g = 0;
    while (!bus.wr_ready_o && g < 2000) begin
      step();
      g++;
    end
    check("wr_accept", bus.wr_ready_o, 1'b1);
    step();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.busy_o && g < 2000) begin
      step();
      g++;
    end
    check(tag, bus.busy_o, 1'b0);
  endtask

  task automatic wait_done(input int s, output int lat);
    int g = 0;
    while (!bus.rd_done_o && g < 1000) begin
      step();
      g++;
    end
    lat = cycle - s;
  endtask

  task automatic do_readback(output int lat);
    int s;
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = tmem[i];
    bus.rd_start_i = 1'b1;
    s = cycle;
    step();
    bus.rd_start_i = 1'b0;
    wait_done(s, lat);
  endtask

  task automatic read_buf(input int a, input logic [31:0] exp);
    bus.cap_addr_i = AW'(a);
    step();
    check($sformatf("cap[%0d]", a), bus.cap_data_o, exp);
  endtask

  task automatic check_buffer();
    for (int i = 0; i < DEPTH; i++) read_buf(i, exp_buf[i]);
  endtask

  initial begin
    int lat, n, g, s, lc;
    logic [31:0] d;
    rst            = 1'b1;
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.rd_start_i = 1'b0;
    bus.cap_addr_i = '0;
    bus.tgt_busy_i = 1'b0;
    bus.tgt_data_i = '0;
    for (int i = 0; i < DEPTH; i++) tmem[i] = 32'(i * 3);

    // Reset state
    step(); step();
    check("rst_load", bus.tgt_load_o, 1'b0);
    check("rst_tdata", bus.tgt_data_o, '0);
    check("rst_tkey", bus.tgt_key_o, '0);
    check("rst_done", bus.rd_done_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_cap", bus.cap_data_o, '0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_ready", bus.wr_ready_o, 1'b1);
    rst = 1'b0;
    step();

    // Single write with a one-cycle busy acknowledge
    busy_len = 1;
    lc = load_count;
    host_write(7'd5, 32'hDEADBEEF);
    check("t1_busy_during", bus.busy_o, 1'b1);
    wait_idle("t1_idle");
    check("t1_ready", bus.wr_ready_o, 1'b1);
    check("t1_err", bus.err_o, 1'b0);
    check("t1_loads", load_count - lc, 1);
    tmem[5] = 32'(5 * 3);
    host_write(7'd5, 32'(15));
    wait_idle("t1_restore_idle");

    // Readback of mem[i] = i*3
    do_readback(lat);
    check("t2_latency", lat, RD_LAT);
    read_buf(10, 32'd30);
    check_buffer();

    // Target never raises busy -> timeout, then cleared by the next write
    busy_len = 0;
    host_write(7'h11, 32'h1234_5678);
    g = 0;
    while (!bus.err_o && g < 4 * TIMEOUT) begin
      step();
      g++;
    end
    n = cycle - last_wr_load;
    check("t3_err", bus.err_o, 1'b1);
    check("t3_window", (n >= TIMEOUT + 1) && (n <= TIMEOUT + 2), 1'b1);
    check("t3_idle", bus.busy_o, 1'b0);
    busy_len = 2;
    host_write(7'h12, 32'hCAFE_F00D);
    check("t3_err_clear", bus.err_o, 1'b0);
    wait_idle("t3_idle2");
    check("t3_err_stays_clear", bus.err_o, 1'b0);

    // Three back-to-back writes, each waiting for the previous busy pulse
    wr_loads.delete();
    wr_lens.delete();
    lc = load_count;
    for (int i = 0; i < 3; i++) begin
      busy_len = int'($urandom_range(1, 4));
      host_write(7'(i), $urandom);
    end
    wait_idle("t6_idle");
    check("t6_loads", load_count - lc, 3);
    for (int i = 1; i < wr_loads.size(); i++)
      check("t6_after_busy", wr_loads[i] - wr_loads[i-1] > wr_lens[i-1] + 1, 1'b1);

    // Random writes with random busy lengths, then a full readback
    for (int k = 0; k < 16; k++) begin
      busy_len = int'($urandom_range(1, 6));
      host_write(7'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) wait_idle("rnd_idle");
    end
    wait_idle("rnd_idle_final");
    do_readback(lat);
    check("rnd_latency", lat, RD_LAT);
    check_buffer();

    // Readback and write requested together: readback wins, write waits for rd_done
    busy_len = 3;
    d = $urandom;
    exp_data_q.push_back({1'b1, 95'b0, d});
    exp_key_q.push_back({121'b0, 7'h33});
    bus.wr_addr_i  = 7'h33;
    bus.wr_data_i  = d;
    bus.wr_valid_i = 1'b1;
    bus.rd_start_i = 1'b1;
    #1;
    check("t4_ready_low", bus.wr_ready_o, 1'b0);
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = tmem[i];
    s = cycle;
    step();
    bus.rd_start_i = 1'b0;
    wait_done(s, lat);
    check("t4_latency", lat, RD_LAT);
    g = 0;
    while (!bus.wr_ready_o && g < 50) begin
      step();
      g++;
    end
    check("t4_ready", bus.wr_ready_o, 1'b1);
    step();
    bus.wr_valid_i = 1'b0;
    wait_idle("t4_idle");
    check("t4_wr_after_done", last_wr_load > last_done, 1'b1);

    // Reset during capture of word 40: words 0..39 new, the rest from the previous capture
    for (int i = 0; i < DEPTH; i++) tmem[i] = $urandom;
    for (int i = 0; i < 40; i++) exp_buf[i] = tmem[i];
    bus.rd_start_i = 1'b1;
    s = cycle;
    step();
    bus.rd_start_i = 1'b0;
    while (cycle < s + 1 + RD_SKIP + 1 + 40) step();
    check("t5_in_capture", bus.busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_load", bus.tgt_load_o, 1'b0);
    check("t5_tdata", bus.tgt_data_o, '0);
    check("t5_tkey", bus.tgt_key_o, '0);
    check("t5_done", bus.rd_done_o, 1'b0);
    check("t5_err", bus.err_o, 1'b0);
    check("t5_cap", bus.cap_data_o, '0);
    check("t5_busy", bus.busy_o, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_buffer();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end
endmodule
